// File: rtl/axil_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : axil_cmd_master
// Function : valid/ready command stream to single AXI4-Lite transactions.
//            Optional watchdog enabled by `define AXIL_MASTER_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module axil_cmd_master #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_wstrb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic [1:0]          rsp_resp_o,
  output logic                rsp_timeout_o,
  output logic                m_axi_awvalid_o,
  input  logic                m_axi_awready_i,
  output logic [ADDR_W-1:0]   m_axi_awaddr_o,
  output logic [2:0]          m_axi_awprot_o,
  output logic                m_axi_wvalid_o,
  input  logic                m_axi_wready_i,
  output logic [DATA_W-1:0]   m_axi_wdata_o,
  output logic [DATA_W/8-1:0] m_axi_wstrb_o,
  input  logic                m_axi_bvalid_i,
  output logic                m_axi_bready_o,
  input  logic [1:0]          m_axi_bresp_i,
  output logic                m_axi_arvalid_o,
  input  logic                m_axi_arready_i,
  output logic [ADDR_W-1:0]   m_axi_araddr_o,
  output logic [2:0]          m_axi_arprot_o,
  input  logic                m_axi_rvalid_i,
  output logic                m_axi_rready_o,
  input  logic [DATA_W-1:0]   m_axi_rdata_i,
  input  logic [1:0]          m_axi_rresp_i
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WR = 2'd1, S_RD = 2'd2, S_RESP = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                arvalid_q, arvalid_d, rready_q, rready_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_accept, w_expire;

  assign w_aw_hs  = awvalid_q & m_axi_awready_i;
  assign w_w_hs   = wvalid_q & m_axi_wready_i;
  assign w_b_hs   = bready_q & m_axi_bvalid_i;
  assign w_ar_hs  = arvalid_q & m_axi_arready_i;
  assign w_r_hs   = rready_q & m_axi_rvalid_i;
  assign w_accept = cmd_valid_i & cmd_ready_o;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q, timeout_d;

  // Counter restarts at command acceptance, i.e. on entry to WR/RD.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_accept)
      cnt_q <= '0;
    else if (state_q == S_WR || state_q == S_RD)
      cnt_q <= cnt_q + 1'b1;
  end

  assign w_expire      = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign rsp_timeout_o = timeout_q;
`else
  assign w_expire      = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
`ifdef AXIL_MASTER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
`ifdef AXIL_MASTER_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
`ifdef AXIL_MASTER_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          addr_d    = cmd_addr_i;
          wdata_d   = cmd_wdata_i;
          wstrb_d   = cmd_wstrb_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (cmd_write_i) begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WR: begin
        if (w_aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (w_b_hs) begin
          bready_d = 1'b0;
          rdata_d  = '0;
          resp_d   = m_axi_bresp_i;
          state_d  = S_RESP;
`ifdef AXIL_MASTER_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end else if (w_expire) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b0;
          rdata_d   = '0;
          resp_d    = 2'b10;
          state_d   = S_RESP;
`ifdef AXIL_MASTER_TIMEOUT_EN
          timeout_d = 1'b1;
`endif
        end else if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
        end
      end
      S_RD: begin
        // Terminal handshake outranks an expiry in the same cycle.
        if (w_r_hs) begin
          rready_d = 1'b0;
          rdata_d  = m_axi_rdata_i;
          resp_d   = m_axi_rresp_i;
          state_d  = S_RESP;
`ifdef AXIL_MASTER_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end else if (w_expire) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b0;
          rdata_d   = '0;
          resp_d    = 2'b10;
          state_d   = S_RESP;
`ifdef AXIL_MASTER_TIMEOUT_EN
          timeout_d = 1'b1;
`endif
        end else if (w_ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready_o     = (state_q == S_IDLE) & ~rst_i;
  assign rsp_valid_o     = (state_q == S_RESP);
  assign rsp_rdata_o     = rdata_q;
  assign rsp_resp_o      = resp_q;
  assign m_axi_awvalid_o = awvalid_q;
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awprot_o  = 3'b000;
  assign m_axi_wvalid_o  = wvalid_q;
  assign m_axi_wdata_o   = wdata_q;
  assign m_axi_wstrb_o   = wstrb_q;
  assign m_axi_bready_o  = bready_q;
  assign m_axi_arvalid_o = arvalid_q;
  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arprot_o  = 3'b000;
  assign m_axi_rready_o  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_cmd_master
// Function : directed self-checking bench for axil_cmd_master with a small
//            AXI4-Lite slave model.
// Revision : 1.0
// ============================================================================
module tb_axil_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic [1:0]  bresp, rresp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axil_cmd_master #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_resp_o(rsp_resp), .rsp_timeout_o(rsp_timeout),
    .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready), .m_axi_awaddr_o(awaddr),
    .m_axi_awprot_o(awprot), .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
    .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_bvalid_i(bvalid),
    .m_axi_bready_o(bready), .m_axi_bresp_i(bresp), .m_axi_arvalid_o(arvalid),
    .m_axi_arready_i(arready), .m_axi_araddr_o(araddr), .m_axi_arprot_o(arprot),
    .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready), .m_axi_rdata_i(rdata),
    .m_axi_rresp_i(rresp)
  );

  // Slave model: AW always ready, W ready after w_delay waiting cycles,
  // AR ready unless ar_block; B/R presented the cycle after acceptance.
  int          w_delay = 0;
  logic        ar_block = 1'b0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;
  int          w_cnt = 0;
  int          ar_hs_cnt = 0;
  logic        aw_got, w_got;

  assign awready = 1'b1;
  assign wready  = (w_cnt >= w_delay);
  assign arready = ~ar_block;
  assign bresp   = cfg_bresp;
  assign rresp   = cfg_rresp;
  assign rdata   = cfg_rdata;

  always @(posedge clk) begin
    if (rst) begin
      w_cnt  <= 0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      bvalid <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      w_cnt <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (awvalid && awready) aw_got <= 1'b1;
      if (wvalid && wready)   w_got  <= 1'b1;
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else if (!bvalid && (aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        bvalid <= 1'b1;
      end
      if (rvalid && rready)
        rvalid <= 1'b0;
      else if (arvalid && arready)
        rvalid <= 1'b1;
    end
  end

  always @(posedge clk)
    if (!rst && arvalid && arready) ar_hs_cnt <= ar_hs_cnt + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge of cycle N+1, N being the acceptance cycle.
  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int i;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    i = 0;
    #1;
    while (!cmd_ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (!cmd_ready) check_val("cmd_accept_wait", 0, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) check_val("rsp_wait", 0, 1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_val("rsp_done_valid", rsp_valid, 0);
    check_val("rsp_done_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    int lat;
    int ar_before;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_cmd_ready", cmd_ready, 0);
    check_val("rst_valids", {rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 6'b0);
    check_val("rst_payload", {rsp_rdata, rsp_resp, rsp_timeout}, 35'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_cmd_ready", cmd_ready, 1);

    // Zero-wait write
    send_cmd(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF);
    check_val("wr1_n1_valids", {awvalid, wvalid, bready}, 3'b110);
    check_val("wr1_awaddr", awaddr, 32'h0000_0010);
    check_val("wr1_wdata", {wdata, wstrb}, {32'hA5A5_5A5A, 4'hF});
    check_val("wr1_prot", {awprot, arprot}, 6'b0);
    @(negedge clk);
    check_val("wr1_n2", {awvalid, wvalid, bready, rsp_valid}, 4'b0010);
    @(negedge clk);
    check_val("wr1_n3_rsp_valid", rsp_valid, 1);
    check_val("wr1_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 35'd0);
    take_rsp();

    // Write with W delayed 4 cycles after AW, DECERR passed through
    w_delay = 4; cfg_bresp = 2'b11;
    send_cmd(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'h3);
    check_val("wr2_n1", {awvalid, wvalid, bready}, 3'b110);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check_val($sformatf("wr2_n%0d", k), {awvalid, wvalid, bready, rsp_valid}, 4'b0100);
    end
    @(negedge clk);
    check_val("wr2_n6", {awvalid, wvalid, bready, rsp_valid}, 4'b0010);
    @(negedge clk);
    check_val("wr2_n7_rsp", {rsp_valid, rsp_resp, rsp_timeout}, {1'b1, 2'b11, 1'b0});
    check_val("wr2_rdata", rsp_rdata, 0);
    take_rsp();
    @(negedge clk);
    check_val("wr2_single_rsp", {rsp_valid, bready, awvalid, wvalid}, 4'b0);
    w_delay = 0; cfg_bresp = 2'b00;

    // Read with SLVERR, no retry
    cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b10;
    ar_before = ar_hs_cnt;
    send_cmd(1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF);
    check_val("rd1_n1", {arvalid, rready, awvalid, wvalid}, 4'b1000);
    check_val("rd1_araddr", araddr, 32'h0000_0004);
    @(negedge clk);
    check_val("rd1_n2", {arvalid, rready}, 2'b01);
    @(negedge clk);
    check_val("rd1_n3_rsp", {rsp_valid, rsp_resp, rsp_timeout}, {1'b1, 2'b10, 1'b0});
    check_val("rd1_rdata", rsp_rdata, 32'h1234_5678);

    // Hold the response 10 cycles with a command waiting
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_val($sformatf("hold_%0d", k),
                {rsp_valid, rsp_rdata, rsp_resp, cmd_ready, awvalid, wvalid, arvalid, rready},
                {1'b1, 32'h1234_5678, 2'b10, 5'b0});
    end
    cmd_valid = 1'b0;
    take_rsp();
    repeat (3) @(negedge clk);
    check_val("rd1_no_retry", ar_hs_cnt - ar_before, 1);
    check_val("rd1_idle_after", {arvalid, rsp_valid, awvalid}, 3'b0);

    // Reset while arvalid high
    ar_block = 1'b1;
    send_cmd(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    @(negedge clk);
    check_val("rst_mid_arvalid", arvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_mid_drop", {arvalid, rready, awvalid, wvalid, bready, rsp_valid, cmd_ready}, 7'b0);
    rst = 1'b0; ar_block = 1'b0;
    cfg_rdata = 32'hCAFE_F00D; cfg_rresp = 2'b00;
    send_cmd(1'b0, 32'h0000_000C, 32'h0, 4'h0);
    check_val("rd2_araddr", araddr, 32'h0000_000C);
    wait_rsp(lat);
    check_val("rd2_latency", lat, 3);
    check_val("rd2_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, {32'hCAFE_F00D, 2'b00, 1'b0});
    take_rsp();

`ifdef AXIL_MASTER_TIMEOUT_EN
    // Watchdog: arready never asserted, TIMEOUT_CYC = 16
    ar_block = 1'b1;
    send_cmd(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    wait_rsp(lat);
    check_val("to_latency", lat, 17);
    check_val("to_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, {32'h0, 2'b10, 1'b1});
    check_val("to_axi_idle", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    take_rsp();
    ar_block = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
